// File: rtl/bp_be_clint_mmio.sv
// bp_be_clint_mmio -- core-local interruptor (CLINT) on the BE MMIO path.
//
// One free-running 64-bit mtime shared by all harts, plus per-hart mtimecmp
// and msip registers. Each is mapped at a fixed 8-byte-aligned address; per-hart
// registers use an 8-byte stride from their base. Requests use a valid/ready
// handshake, and responses use a valid/yumi handshake. Only one request can be
// outstanding at a time.
//
// Ports
//   clk_i, reset_i      clock, synchronous active-high reset
//   v_i / ready_o       request valid / block can accept a request
//   w_i, addr_i, data_i request: 1 = write, address (8 B aligned), write data
//   v_o / yumi_i        response valid / response consumed
//   data_o, err_o       read data (0 for writes); unmapped/misaligned flag
//   timer_irq_o         per-hart registered (mtime >= mtimecmp[h])
//   soft_irq_o          per-hart registered msip[h]
//   prescale_i          mtime tick divisor-1 (only with BP_CLINT_PRESCALE_EN)
//
// Optional feature: define BP_CLINT_PRESCALE_EN to add prescale_i. With it,
// mtime advances once every (prescale_i + 1) cycles. Without it, mtime ticks
// every cycle.

module bp_be_clint_mmio #(
    parameter int unsigned               num_harts_p      = 1,
    parameter int unsigned               paddr_width_p    = 39,
    parameter logic [paddr_width_p-1:0]  mtime_addr_p     = 39'h6f_ffff_0000,
    parameter logic [paddr_width_p-1:0]  mtimecmp_base_p  = 39'h6f_ffff_0100,
    parameter logic [paddr_width_p-1:0]  msip_base_p      = 39'h6f_ffff_0200,
    parameter int unsigned               prescale_width_p = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic                     w_i,
    input  logic [paddr_width_p-1:0] addr_i,
    input  logic [63:0]              data_i,
    output logic                     v_o,
    output logic [63:0]              data_o,
    output logic                     err_o,
    input  logic                     yumi_i,
    output logic [num_harts_p-1:0]   timer_irq_o,
    output logic [num_harts_p-1:0]   soft_irq_o
`ifdef BP_CLINT_PRESCALE_EN
    ,
    input  logic [prescale_width_p-1:0] prescale_i
`endif
);

    if (num_harts_p < 1 || num_harts_p > 32 || prescale_width_p < 1) begin : g_param_check
        $error("bp_be_clint_mmio: num_harts_p must be 1..32 and prescale_width_p >= 1");
    end

    typedef enum logic {e_ready, e_resp} state_e;

    state_e                 state;
    logic [63:0]            mtime;
    logic [63:0]            mtimecmp [num_harts_p];
    logic [num_harts_p-1:0] msip;

    logic                   aligned;
    logic                   hit_mtime;
    logic [num_harts_p-1:0] hit_cmp;
    logic [num_harts_p-1:0] hit_sip;
    logic                   dec_err;
    logic [63:0]            rd_data;
    logic                   accept;
    logic                   wr_en;
    logic [num_harts_p-1:0] msip_n;
    logic                   tick;

    assign ready_o = (state == e_ready);
    assign v_o     = (state == e_resp);
    assign accept  = v_i && ready_o;
    assign wr_en   = accept && w_i && !dec_err;

    // Address decode and read mux. These use the register values before the
    // accepting edge, so a read of mtime returns the pre-increment count.
    always_comb begin
        aligned   = (addr_i[2:0] == 3'b000);
        hit_mtime = aligned && (addr_i == mtime_addr_p);
        hit_cmp   = '0;
        hit_sip   = '0;
        rd_data   = '0;
        if (hit_mtime) rd_data = mtime;
        for (int unsigned h = 0; h < num_harts_p; h++) begin
            hit_cmp[h] = aligned && (addr_i == mtimecmp_base_p + paddr_width_p'(8 * h));
            hit_sip[h] = aligned && (addr_i == msip_base_p + paddr_width_p'(8 * h));
            if (hit_cmp[h]) rd_data = mtimecmp[h];
            if (hit_sip[h]) rd_data = {63'b0, msip[h]};
        end
        dec_err = !(hit_mtime || (|hit_cmp) || (|hit_sip));
        if (w_i || dec_err) rd_data = '0;
    end

    // The next msip value feeds both the register and soft_irq_o. As a
    // result, the interrupt follows a write with a single cycle of latency.
    always_comb begin
        msip_n = msip;
        for (int unsigned h = 0; h < num_harts_p; h++) begin
            if (wr_en && hit_sip[h]) msip_n[h] = data_i[0];
        end
    end

`ifdef BP_CLINT_PRESCALE_EN
    logic [prescale_width_p-1:0] pre_cnt;
    assign tick = (pre_cnt == prescale_i);
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= e_ready;
            data_o      <= '0;
            err_o       <= 1'b0;
            mtime       <= '0;
            msip        <= '0;
            timer_irq_o <= '0;
            soft_irq_o  <= '0;
            for (int unsigned h = 0; h < num_harts_p; h++) begin
                mtimecmp[h] <= '1;
            end
`ifdef BP_CLINT_PRESCALE_EN
            pre_cnt     <= '0;
`endif
        end else begin
            case (state)
                e_ready: begin
                    if (accept) begin
                        state  <= e_resp;
                        data_o <= rd_data;
                        err_o  <= dec_err;
                    end
                end
                e_resp: begin
                    if (yumi_i) state <= e_ready;
                end
                default: state <= e_ready;
            endcase

            // A software write takes priority over the tick in the same cycle.
            if (wr_en && hit_mtime) begin
                mtime <= data_i;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

`ifdef BP_CLINT_PRESCALE_EN
            if ((wr_en && hit_mtime) || tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
`endif

            for (int unsigned h = 0; h < num_harts_p; h++) begin
                if (wr_en && hit_cmp[h]) mtimecmp[h] <= data_i;
                timer_irq_o[h] <= (mtime >= mtimecmp[h]);
            end

            msip       <= msip_n;
            soft_irq_o <= msip_n;
        end
    end

endmodule
